// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stage-register sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exme;
    logic mewb;
  } en_vec_t;

  typedef struct packed {
    logic flush_ifid;
    logic flush_idex;
    logic bubble_mewb;
  } fb_vec_t;

  typedef struct packed {
    en_vec_t en;
    fb_vec_t fb;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_IDLE   = stage_ctl_t'(8'b00000_000);
  localparam stage_ctl_t CTL_RUN    = stage_ctl_t'(8'b11111_000);
  localparam stage_ctl_t CTL_FREEZE = stage_ctl_t'(8'b00001_001);
  localparam stage_ctl_t CTL_BRANCH = stage_ctl_t'(8'b11111_110);
  localparam stage_ctl_t CTL_LU     = stage_ctl_t'(8'b00111_010);

  // Flow control once memory is not stalling: a taken branch squashes the
  // wrong-path ID instruction, so it wins over a load-use hazard.
  function automatic stage_ctl_t flow_ctl(input logic branch, input logic lu);
    if (branch) return CTL_BRANCH;
    if (lu)     return CTL_LU;
    return CTL_RUN;
  endfunction

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard detector: EX-stage load whose destination feeds the ID instruction.
module lu_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       use_rt_id,
  input  logic [4:0] rw_ex,
  input  logic       wreg_ex,
  input  logic       m2reg_ex,
  output logic       lu
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (rw_ex == rs_id);
  assign w_rt_hit = use_rt_id && (rw_ex == rt_id);
  assign lu       = m2reg_ex && wreg_ex && (rw_ex != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stage-register sequencer: load enables, flush/bubble controls, memory
// handshake FSM with timeout, and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMR_W       = 5,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rt_id,
  input  logic [4:0]       rw_ex,
  input  logic             wreg_ex,
  input  logic             m2reg_ex,
  input  logic             branch_ex,
  input  logic             memop_me,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exme,
  output logic             en_mewb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             bubble_mewb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nx;
  logic             r_err;
  logic             w_err_set;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lu;
  logic             w_req;
  stage_ctl_t       w_ctl;
  stage_ctl_t       w_ctl_out;

  lu_detect u_lu_detect (
    .rs_id     (rs_id),
    .rt_id     (rt_id),
    .use_rt_id (use_rt_id),
    .rw_ex     (rw_ex),
    .wreg_ex   (wreg_ex),
    .m2reg_ex  (m2reg_ex),
    .lu        (w_lu)
  );

  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_err_set  = 1'b0;
    w_req      = 1'b0;
    w_ctl      = CTL_IDLE;
    case (r_state)
      ST_RUN: begin
        w_req = memop_me;
        if (memop_me && !mem_ready) begin
          w_ctl      = CTL_FREEZE;
          w_state_nx = ST_MWAIT;
          w_tmr_nx   = TMR_W'(1);
        end else begin
          w_ctl = flow_ctl(branch_ex, w_lu);
        end
      end
      ST_MWAIT: begin
        w_req = 1'b1;
        if (mem_ready) begin
          w_ctl      = flow_ctl(branch_ex, w_lu);
          w_state_nx = ST_RUN;
          w_tmr_nx   = '0;
        end else if (r_tmr == TMR_LAST) begin
          w_ctl      = CTL_FREEZE;
          w_state_nx = ST_HALT;
          w_err_set  = 1'b1;
        end else begin
          w_ctl    = CTL_FREEZE;
          w_tmr_nx = r_tmr + TMR_W'(1);
        end
      end
      ST_HALT: begin
        w_ctl = CTL_FREEZE;
      end
      default: begin
        w_state_nx = ST_RUN;
        w_tmr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset_0) begin
    if (reset_0) begin
      r_state <= ST_RUN;
      r_tmr   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tmr   <= w_tmr_nx;
      if (w_err_set) r_err <= 1'b1;
      if ((r_state != ST_HALT) && !w_ctl.en.pc && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Controls are forced low for as long as reset is held, not just at the edge.
  assign w_ctl_out   = reset_0 ? CTL_IDLE : w_ctl;
  assign mem_req     = w_req && !reset_0;
  assign en_pc       = w_ctl_out.en.pc;
  assign en_ifid     = w_ctl_out.en.ifid;
  assign en_idex     = w_ctl_out.en.idex;
  assign en_exme     = w_ctl_out.en.exme;
  assign en_mewb     = w_ctl_out.en.mewb;
  assign flush_ifid  = w_ctl_out.fb.flush_ifid;
  assign flush_idex  = w_ctl_out.fb.flush_idex;
  assign bubble_mewb = w_ctl_out.fb.bubble_mewb;
  assign mem_err     = r_err;
  assign stall_cnt   = r_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a behavioural pipeline-control model.
module tb_pipe_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset_0;
  logic [4:0]  rs_id, rt_id, rw_ex;
  logic        use_rt_id, wreg_ex, m2reg_ex, branch_ex, memop_me, mem_ready;

  logic        mem_req, en_pc, en_ifid, en_idex, en_exme, en_mewb;
  logic        flush_ifid, flush_idex, bubble_mewb, mem_err;
  logic [31:0] stall_cnt;
  logic [1:0]  state;

  logic        s_mem_req, s_en_pc, s_en_ifid, s_en_idex, s_en_exme, s_en_mewb;
  logic        s_flush_ifid, s_flush_idex, s_bubble_mewb, s_mem_err;
  logic [2:0]  s_stall_cnt;
  logic [1:0]  s_state;

  logic [8:0]  dut_o, s_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // model: waiting on memory, consecutive stalled memory cycles, halted, error, stall count
  bit          m_waiting, m_halted, m_err;
  int unsigned m_stalls;
  logic [31:0] m_cnt;

  always #5 clock = ~clock;

  pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(5), .CNT_W(32)) dut (
    .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
    .use_rt_id(use_rt_id), .rw_ex(rw_ex), .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex),
    .branch_ex(branch_ex), .memop_me(memop_me), .mem_ready(mem_ready),
    .mem_req(mem_req), .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exme(en_exme), .en_mewb(en_mewb), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .bubble_mewb(bubble_mewb), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .state(state)
  );

  pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(5), .CNT_W(3)) dut_s (
    .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
    .use_rt_id(use_rt_id), .rw_ex(rw_ex), .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex),
    .branch_ex(branch_ex), .memop_me(memop_me), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .en_pc(s_en_pc), .en_ifid(s_en_ifid), .en_idex(s_en_idex),
    .en_exme(s_en_exme), .en_mewb(s_en_mewb), .flush_ifid(s_flush_ifid),
    .flush_idex(s_flush_idex), .bubble_mewb(s_bubble_mewb), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .state(s_state)
  );

  assign dut_o = {mem_req, en_pc, en_ifid, en_idex, en_exme, en_mewb,
                  flush_ifid, flush_idex, bubble_mewb};
  assign s_o   = {s_mem_req, s_en_pc, s_en_ifid, s_en_idex, s_en_exme, s_en_mewb,
                  s_flush_ifid, s_flush_idex, s_bubble_mewb};

  function automatic logic model_lu();
    return m2reg_ex && wreg_ex && (rw_ex != 5'd0) &&
           ((rw_ex == rs_id) || (use_rt_id && (rw_ex == rt_id)));
  endfunction

  function automatic logic model_mem_stall();
    return (m_waiting || memop_me) && !mem_ready;
  endfunction

  // {mem_req, en_pc, en_ifid, en_idex, en_exme, en_mewb, flush_ifid, flush_idex, bubble_mewb}
  function automatic logic [8:0] exp_outs();
    logic req;
    if (reset_0)  return 9'b0_00000_000;
    if (m_halted) return 9'b0_00001_001;
    req = memop_me || m_waiting;
    if (model_mem_stall()) return {req, 8'b00001_001};
    if (branch_ex)         return {req, 8'b11111_110};
    if (model_lu())        return {req, 8'b00111_010};
    return {req, 8'b11111_000};
  endfunction

  function automatic logic [1:0] exp_state();
    return m_halted ? 2'd2 : (m_waiting ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [2:0] exp_cnt_s();
    return (m_cnt > 32'd7) ? 3'd7 : m_cnt[2:0];
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_halted = 0; m_err = 0; m_stalls = 0; m_cnt = '0;
  endtask

  task automatic model_edge();
    logic [8:0] o;
    o = exp_outs();
    if (reset_0 || m_halted) return;
    if (!o[7] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (model_mem_stall()) begin
      m_stalls = m_waiting ? m_stalls + 1 : 1;
      if (m_stalls == MEM_TIMEOUT) begin
        m_halted = 1; m_err = 1; m_waiting = 0;
      end else begin
        m_waiting = 1;
      end
    end else begin
      m_waiting = 0; m_stalls = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rs_id = '0; rt_id = '0; rw_ex = '0; use_rt_id = 0; wreg_ex = 0;
    m2reg_ex = 0; branch_ex = 0; memop_me = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_0 = 1;
    model_reset();
    @(negedge clock);
    reset_0 = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_0 = 1; memop_me = 1; branch_ex = 1; m2reg_ex = 1; wreg_ex = 1;
    model_reset();
    @(posedge clock); #1;
    vectors++;
    if (dut_o !== 9'b0) begin
      miscompares++; $display("FAIL reset_outs: got %b exp %b", dut_o, 9'b0);
    end
    vectors++;
    if ({state, mem_err, stall_cnt} !== 35'd0) begin
      miscompares++; $display("FAIL reset_regs: got st=%0d err=%b cnt=%0d exp 0/0/0", state, mem_err, stall_cnt);
    end
    @(negedge clock);
    idle(); reset_0 = 0; #1;
  endtask

  task automatic test_normal();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rs_id = 5'($urandom); rt_id = 5'($urandom); rw_ex = 5'($urandom);
      use_rt_id = 1'($urandom); wreg_ex = 1'($urandom);
      #1;
      vectors++;
      if (dut_o !== 9'b0_11111_000) begin
        miscompares++; $display("FAIL normal_outs[%0d]: got %b exp %b", i, dut_o, 9'b0_11111_000);
      end
      tick();
    end
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++; $display("FAIL normal_cnt: got %0d exp 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    m2reg_ex = 1; wreg_ex = 1; rw_ex = 5'd8; rs_id = 5'd8; #1;
    vectors++;
    if (dut_o !== 9'b0_00111_010) begin
      miscompares++; $display("FAIL lu_rs_outs: got %b exp %b", dut_o, 9'b0_00111_010);
    end
    tick();
    idle(); #1;
    vectors++;
    if (stall_cnt !== 32'd1) begin
      miscompares++; $display("FAIL lu_rs_cnt: got %0d exp 1", stall_cnt);
    end
    m2reg_ex = 1; wreg_ex = 1; rw_ex = 5'd0; rs_id = 5'd0; #1;
    vectors++;
    if (dut_o !== 9'b0_11111_000) begin
      miscompares++; $display("FAIL lu_r0_outs: got %b exp %b", dut_o, 9'b0_11111_000);
    end
    tick();
    rw_ex = 5'd5; rs_id = 5'd3; rt_id = 5'd5; use_rt_id = 1; #1;
    vectors++;
    if (dut_o !== 9'b0_00111_010) begin
      miscompares++; $display("FAIL lu_rt_outs: got %b exp %b", dut_o, 9'b0_00111_010);
    end
    use_rt_id = 0; #1;
    vectors++;
    if (dut_o !== 9'b0_11111_000) begin
      miscompares++; $display("FAIL lu_rt_unused_outs: got %b exp %b", dut_o, 9'b0_11111_000);
    end
    tick();
    vectors++;
    if (stall_cnt !== 32'd1) begin
      miscompares++; $display("FAIL lu_cnt_final: got %0d exp 1", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    m2reg_ex = 1; wreg_ex = 1; rw_ex = 5'd9; rs_id = 5'd9; branch_ex = 1; #1;
    vectors++;
    if (dut_o !== 9'b0_11111_110) begin
      miscompares++; $display("FAIL branch_outs: got %b exp %b", dut_o, 9'b0_11111_110);
    end
    tick();
    idle(); #1;
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++; $display("FAIL branch_cnt: got %0d exp 0", stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    memop_me = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (dut_o !== 9'b1_00001_001) begin
        miscompares++; $display("FAIL mwait_outs[%0d]: got %b exp %b", i, dut_o, 9'b1_00001_001);
      end
      tick();
      vectors++;
      if (state !== 2'd1) begin
        miscompares++; $display("FAIL mwait_state[%0d]: got %0d exp 1", i, state);
      end
    end
    mem_ready = 1; #1;
    vectors++;
    if (dut_o !== 9'b1_11111_000) begin
      miscompares++; $display("FAIL mwait_release: got %b exp %b", dut_o, 9'b1_11111_000);
    end
    tick();
    vectors++;
    if ({state, stall_cnt, s_stall_cnt} !== {2'd0, 32'd3, 3'd3}) begin
      miscompares++; $display("FAIL mwait_end: got st=%0d cnt=%0d scnt=%0d exp 0/3/3", state, stall_cnt, s_stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    memop_me = 1; mem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      vectors++;
      if (dut_o !== exp_outs() || dut_o !== 9'b1_00001_001) begin
        miscompares++; $display("FAIL tmo_outs[%0d]: got %b exp %b", i, dut_o, 9'b1_00001_001);
      end
      tick();
      vectors++;
      if ({state, mem_err} !== {exp_state(), m_err}) begin
        miscompares++; $display("FAIL tmo_state[%0d]: got st=%0d err=%b exp st=%0d err=%b", i, state, mem_err, exp_state(), m_err);
      end
    end
    vectors++;
    if ({state, mem_err, dut_o, stall_cnt, s_stall_cnt} !== {2'd2, 1'b1, 9'b0_00001_001, 32'd16, 3'd7}) begin
      miscompares++; $display("FAIL tmo_halt: got st=%0d err=%b o=%b cnt=%0d scnt=%0d exp 2/1/000001001/16/7", state, mem_err, dut_o, stall_cnt, s_stall_cnt);
    end
    mem_ready = 1; branch_ex = 1;
    repeat (3) tick();
    vectors++;
    if ({state, mem_err, dut_o, stall_cnt} !== {2'd2, 1'b1, 9'b0_00001_001, 32'd16}) begin
      miscompares++; $display("FAIL tmo_stuck: got st=%0d err=%b o=%b cnt=%0d exp 2/1/000001001/16", state, mem_err, dut_o, stall_cnt);
    end
    do_reset();
    vectors++;
    if ({state, mem_err, stall_cnt} !== 35'd0) begin
      miscompares++; $display("FAIL tmo_cleared: got st=%0d err=%b cnt=%0d exp 0/0/0", state, mem_err, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    memop_me = 1; mem_ready = 0;
    tick(); tick();
    #2;
    reset_0 = 1;
    model_reset();
    #1;
    vectors++;
    if ({dut_o, state, mem_err, stall_cnt} !== 44'd0) begin
      miscompares++; $display("FAIL midrst_async: got o=%b st=%0d err=%b cnt=%0d exp all 0", dut_o, state, mem_err, stall_cnt);
    end
    @(negedge clock);
    idle(); reset_0 = 0; #1;
    tick();
    vectors++;
    if ({dut_o, state, mem_err, stall_cnt} !== {9'b0_11111_000, 2'd0, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL midrst_after: got o=%b st=%0d err=%b cnt=%0d exp 011111000/0/0/0", dut_o, state, mem_err, stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
      rw_ex = 5'($urandom_range(0, 3)); use_rt_id = 1'($urandom);
      wreg_ex = ($urandom_range(0, 3) != 0); m2reg_ex = 1'($urandom);
      branch_ex = ($urandom_range(0, 5) == 0); memop_me = ($urandom_range(0, 2) == 0);
      mem_ready = 1'($urandom);
      #1;
      vectors++;
      if (dut_o !== exp_outs() || s_o !== exp_outs()) begin
        miscompares++; $display("FAIL rand_outs[%0d]: got %b/%b exp %b", i, dut_o, s_o, exp_outs());
      end
      tick();
      vectors++;
      if ({state, mem_err, stall_cnt, s_stall_cnt, s_state, s_mem_err} !==
          {exp_state(), m_err, m_cnt, exp_cnt_s(), exp_state(), m_err}) begin
        miscompares++;
        $display("FAIL rand_regs[%0d]: got st=%0d err=%b cnt=%0d scnt=%0d exp st=%0d err=%b cnt=%0d scnt=%0d",
                 i, state, mem_err, stall_cnt, s_stall_cnt, exp_state(), m_err, m_cnt, exp_cnt_s());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_0 = 1;
    model_reset();
    #3;
    test_reset();
    test_normal();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
